msx_slot_master: RTL and testbench

Initiator-side counterpart of the cartridge slot bridge. It converts single transfers on the internal request bus (valid/ready plus a read-data strobe) into Z80-style MSX slot memory and I/O cycles, generating SLTSL/MREQ/IORQ/RD/WR, address and data with programmable setup, strobe and hold timing. It honours the slot WAIT line. It is used as the MSX-host model in loopback benches and as the host-side engine for driving an external cartridge from the FPGA.

---
 rtl/msx_slot_master.sv | 154 +++++++++++++++
 tb/tb_msx_slot_master.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/msx_slot_master.sv
// MSX slot master: turns single request-bus transfers into Z80-style slot
// memory/I/O cycles with programmable setup, strobe and hold timing.
//
// Ports:
//   clk42m, reset           system clock, synchronous active-high reset
//   bus_*                   request bus (valid/ready) plus read-data strobe
//   p_slot_*_n              active-low slot control lines and slot reset
//   p_slot_address          slot address
//   p_slot_data_out/_oe/_in slot data bus (split direction)
//   p_slot_wait             target wait-state request
module msx_slot_master #(
  parameter int SETUP_CYCLES  = 4,
  parameter int STROBE_CYCLES = 20,
  parameter int HOLD_CYCLES   = 4,
  parameter int WAIT_TIMEOUT  = 255
) (
  input  logic        clk42m,
  input  logic        reset,
  input  logic        bus_memreq,
  input  logic        bus_ioreq,
  input  logic [15:0] bus_address,
  input  logic        bus_write,
  input  logic        bus_valid,
  output logic        bus_ready,
  input  logic [7:0]  bus_wdata,
  output logic [7:0]  bus_rdata,
  output logic        bus_rdata_en,
  output logic        p_slot_reset_n,
  output logic        p_slot_sltsl_n,
  output logic        p_slot_mreq_n,
  output logic        p_slot_ioreq_n,
  output logic        p_slot_rd_n,
  output logic        p_slot_wr_n,
  output logic [15:0] p_slot_address,
  output logic [7:0]  p_slot_data_out,
  output logic        p_slot_data_oe,
  input  logic [7:0]  p_slot_data_in,
  input  logic        p_slot_wait
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD
  } state_t;

  localparam logic [5:0] SETUP_LAST  = 6'(SETUP_CYCLES - 1);
  localparam logic [5:0] STROBE_LAST = 6'(STROBE_CYCLES - 1);
  localparam logic [5:0] HOLD_LAST   = 6'(HOLD_CYCLES - 1);
  localparam logic [7:0] WAIT_MAX    = 8'(WAIT_TIMEOUT);

  state_t     state;
  logic [5:0] cnt;
  logic [7:0] wait_cnt;
  logic       is_write;

  logic stretch;
  logic abort;

  // The strobe counter parks on its last count while WAIT is asserted;
  // abort once the extension budget is used up.
  assign stretch = p_slot_wait && (wait_cnt != WAIT_MAX);
  assign abort   = p_slot_wait && (wait_cnt == WAIT_MAX);

  assign bus_ready = (state == S_IDLE) && !reset;

  always_ff @(posedge clk42m) begin
    p_slot_reset_n <= ~reset;
    if (reset) begin
      state           <= S_IDLE;
      cnt             <= '0;
      wait_cnt        <= '0;
      is_write        <= 1'b0;
      bus_rdata       <= '0;
      bus_rdata_en    <= 1'b0;
      p_slot_sltsl_n  <= 1'b1;
      p_slot_mreq_n   <= 1'b1;
      p_slot_ioreq_n  <= 1'b1;
      p_slot_rd_n     <= 1'b1;
      p_slot_wr_n     <= 1'b1;
      p_slot_address  <= '0;
      p_slot_data_out <= '0;
      p_slot_data_oe  <= 1'b0;
    end else begin
      bus_rdata_en <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (bus_valid) begin
            if (bus_memreq || bus_ioreq) begin
              is_write        <= bus_write;
              p_slot_address  <= bus_address;
              p_slot_sltsl_n  <= ~bus_memreq;
              p_slot_mreq_n   <= ~bus_memreq;
              p_slot_ioreq_n  <= bus_memreq;
              p_slot_data_oe  <= bus_write;
              p_slot_data_out <= bus_write ? bus_wdata : 8'h00;
              cnt             <= '0;
              wait_cnt        <= '0;
              state           <= S_SETUP;
            end else if (!bus_write) begin
              // Null read: nothing on the slot, float-bus value back.
              bus_rdata    <= 8'hFF;
              bus_rdata_en <= 1'b1;
            end
          end
        end
        S_SETUP: begin
          if (cnt == SETUP_LAST) begin
            cnt         <= '0;
            p_slot_rd_n <= is_write;
            p_slot_wr_n <= ~is_write;
            state       <= S_STROBE;
          end else begin
            cnt <= cnt + 6'd1;
          end
        end
        S_STROBE: begin
          if (cnt != STROBE_LAST) begin
            cnt <= cnt + 6'd1;
          end else if (stretch) begin
            if (wait_cnt != 8'hFF) begin
              wait_cnt <= wait_cnt + 8'd1;
            end
          end else begin
            p_slot_sltsl_n <= 1'b1;
            p_slot_mreq_n  <= 1'b1;
            p_slot_ioreq_n <= 1'b1;
            p_slot_rd_n    <= 1'b1;
            p_slot_wr_n    <= 1'b1;
            if (!is_write) begin
              bus_rdata    <= abort ? 8'hFF : p_slot_data_in;
              bus_rdata_en <= 1'b1;
            end
            cnt   <= '0;
            state <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (cnt == HOLD_LAST) begin
            p_slot_address  <= '0;
            p_slot_data_out <= '0;
            p_slot_data_oe  <= 1'b0;
            cnt             <= '0;
            state           <= S_IDLE;
          end else begin
            cnt <= cnt + 6'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_msx_slot_master.sv
// Bench for msx_slot_master: table of single transfers with per-cycle
// observation of the slot lines, plus reset and back-to-back sequences.
module tb_msx_slot_master;

  logic        clk42m = 1'b0;
  logic        reset = 1'b1;
  logic        bus_memreq = 1'b0;
  logic        bus_ioreq = 1'b0;
  logic [15:0] bus_address = '0;
  logic        bus_write = 1'b0;
  logic        bus_valid = 1'b0;
  logic        bus_ready;
  logic [7:0]  bus_wdata = '0;
  logic [7:0]  bus_rdata;
  logic        bus_rdata_en;
  logic        p_slot_reset_n;
  logic        p_slot_sltsl_n;
  logic        p_slot_mreq_n;
  logic        p_slot_ioreq_n;
  logic        p_slot_rd_n;
  logic        p_slot_wr_n;
  logic [15:0] p_slot_address;
  logic [7:0]  p_slot_data_out;
  logic        p_slot_data_oe;
  logic [7:0]  p_slot_data_in = 8'hEE;
  logic        p_slot_wait = 1'b0;

  int errors = 0;
  int checks = 0;

  msx_slot_master #(
    .SETUP_CYCLES (4),
    .STROBE_CYCLES(20),
    .HOLD_CYCLES  (4),
    .WAIT_TIMEOUT (16)
  ) dut (
    .clk42m         (clk42m),
    .reset          (reset),
    .bus_memreq     (bus_memreq),
    .bus_ioreq      (bus_ioreq),
    .bus_address    (bus_address),
    .bus_write      (bus_write),
    .bus_valid      (bus_valid),
    .bus_ready      (bus_ready),
    .bus_wdata      (bus_wdata),
    .bus_rdata      (bus_rdata),
    .bus_rdata_en   (bus_rdata_en),
    .p_slot_reset_n (p_slot_reset_n),
    .p_slot_sltsl_n (p_slot_sltsl_n),
    .p_slot_mreq_n  (p_slot_mreq_n),
    .p_slot_ioreq_n (p_slot_ioreq_n),
    .p_slot_rd_n    (p_slot_rd_n),
    .p_slot_wr_n    (p_slot_wr_n),
    .p_slot_address (p_slot_address),
    .p_slot_data_out(p_slot_data_out),
    .p_slot_data_oe (p_slot_data_oe),
    .p_slot_data_in (p_slot_data_in),
    .p_slot_wait    (p_slot_wait)
  );

  always #5 clk42m = ~clk42m;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk42m);
    #1;
  endtask

  // Expected counts are cycles (T0+c) with the line active; *_f fields are
  // the first such cycle, -1 when never.
  typedef struct {
    string       name;
    bit          mem;
    bit          io;
    bit          wr;
    logic [15:0] addr;
    logic [7:0]  wd;
    logic [7:0]  din;
    int          ws;
    int          wl;
    int          e_sl;
    int          e_mreq;
    int          e_io;
    int          e_rdf;
    int          e_rd;
    int          e_wrf;
    int          e_wr;
    int          e_oe;
    int          e_enf;
    int          e_en;
    logic [7:0]  e_data;
    int          e_rdy;
  } vec_t;

  task automatic run_vec(input vec_t v);
    int sl = 0, mr = 0, io = 0, rd = 0, wr = 0, oe = 0, en = 0;
    int rdf = -1, wrf = -1, enf = -1, rdy = -1;
    int aerr = 0, derr = 0;
    logic [7:0] ed = 8'h00;
    bus_memreq  = v.mem;
    bus_ioreq   = v.io;
    bus_write   = v.wr;
    bus_address = v.addr;
    bus_wdata   = v.wd;
    bus_valid   = 1'b1;
    step();
    // Garbage on the bus after acceptance must be ignored.
    bus_valid   = 1'b0;
    bus_memreq  = 1'b0;
    bus_ioreq   = 1'b1;
    bus_write   = ~v.wr;
    bus_address = 16'hFFFF;
    bus_wdata   = 8'h00;
    for (int c = 1; c <= 60; c++) begin
      p_slot_wait    = (c >= 4 + v.ws) && (c < 4 + v.ws + v.wl);
      p_slot_data_in = p_slot_rd_n ? 8'hEE : v.din;
      if (!p_slot_sltsl_n) sl++;
      if (!p_slot_mreq_n) mr++;
      if (!p_slot_ioreq_n) io++;
      if (!p_slot_rd_n) begin
        rd++;
        if (rdf < 0) rdf = c;
      end
      if (!p_slot_wr_n) begin
        wr++;
        if (wrf < 0) wrf = c;
      end
      if (p_slot_data_oe) begin
        oe++;
        if (p_slot_data_out !== v.wd) derr++;
      end
      if (bus_rdata_en) begin
        en++;
        if (enf < 0) begin
          enf = c;
          ed  = bus_rdata;
        end
      end
      if (bus_ready && rdy < 0) rdy = c;
      if ((!p_slot_sltsl_n || !p_slot_ioreq_n || !p_slot_rd_n ||
           !p_slot_wr_n) && p_slot_address !== v.addr) aerr++;
      step();
    end
    p_slot_wait    = 1'b0;
    p_slot_data_in = 8'hEE;
    bus_ioreq      = 1'b0;
    bus_write      = 1'b0;
    check({v.name, " sltsl_cycles"}, sl, v.e_sl);
    check({v.name, " mreq_cycles"}, mr, v.e_mreq);
    check({v.name, " ioreq_cycles"}, io, v.e_io);
    check({v.name, " rd_first"}, rdf, v.e_rdf);
    check({v.name, " rd_cycles"}, rd, v.e_rd);
    check({v.name, " wr_first"}, wrf, v.e_wrf);
    check({v.name, " wr_cycles"}, wr, v.e_wr);
    check({v.name, " oe_cycles"}, oe, v.e_oe);
    check({v.name, " rdata_en_first"}, enf, v.e_enf);
    check({v.name, " rdata_en_count"}, en, v.e_en);
    if (v.e_en > 0) check({v.name, " rdata"}, int'(ed), int'(v.e_data));
    check({v.name, " ready_back"}, rdy, v.e_rdy);
    check({v.name, " addr_stable"}, aerr, 0);
    check({v.name, " wdata_stable"}, derr, 0);
    check({v.name, " addr_idle"}, int'(p_slot_address), 0);
    check({v.name, " oe_idle"}, int'(p_slot_data_oe), 0);
  endtask

  vec_t vecs[8];

  initial begin
    int acc1, acc2, en_cnt, idle_bad;

    //        name      mem io wr addr      wd     din    ws wl   sl mr io rdf rd wrf wr oe enf en data  rdy
    vecs[0] = '{"memwr", 1, 0, 1, 16'h89AB, 8'h56, 8'h00, 0, 0,  24, 24, 0, -1, 0, 5, 20, 28, -1, 0, 8'h00, 29};
    vecs[1] = '{"iord",  0, 1, 0, 16'h0098, 8'h00, 8'h12, 0, 0,  0, 0, 24, 5, 20, -1, 0, 0, 25, 1, 8'h12, 29};
    vecs[2] = '{"waitrd", 1, 0, 0, 16'h4000, 8'h00, 8'hA5, 18, 7, 29, 29, 0, 5, 25, -1, 0, 0, 30, 1, 8'hA5, 34};
    vecs[3] = '{"tmo",   1, 0, 0, 16'h8001, 8'h00, 8'h3C, 1, 500, 40, 40, 0, 5, 36, -1, 0, 0, 41, 1, 8'hFF, 45};
    vecs[4] = '{"both",  1, 1, 0, 16'h1234, 8'h00, 8'h77, 0, 0,  24, 24, 0, 5, 20, -1, 0, 0, 25, 1, 8'h77, 29};
    vecs[5] = '{"iowr",  0, 1, 1, 16'h00A0, 8'h7E, 8'h00, 0, 0,  0, 0, 24, -1, 0, 5, 20, 28, -1, 0, 8'h00, 29};
    vecs[6] = '{"nullrd", 0, 0, 0, 16'hC000, 8'h00, 8'h00, 0, 0, 0, 0, 0, -1, 0, -1, 0, 0, 1, 1, 8'hFF, 1};
    vecs[7] = '{"nullwr", 0, 0, 1, 16'hC001, 8'h99, 8'h00, 0, 0, 0, 0, 0, -1, 0, -1, 0, 0, -1, 0, 8'h00, 1};

    // Reset state.
    repeat (3) step();
    check("rst ready", int'(bus_ready), 0);
    check("rst slot_reset_n", int'(p_slot_reset_n), 0);
    check("rst ctrl", int'({p_slot_sltsl_n, p_slot_mreq_n, p_slot_ioreq_n,
                            p_slot_rd_n, p_slot_wr_n}), 5'h1F);
    check("rst addr", int'(p_slot_address), 0);
    check("rst dout", int'(p_slot_data_out), 0);
    check("rst oe", int'(p_slot_data_oe), 0);
    check("rst rdata", int'(bus_rdata), 0);
    check("rst rdata_en", int'(bus_rdata_en), 0);
    reset = 1'b0;
    step();
    check("rel slot_reset_n", int'(p_slot_reset_n), 1);
    check("rel ready", int'(bus_ready), 1);

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Reset in the middle of a read strobe.
    bus_memreq  = 1'b1;
    bus_write   = 1'b0;
    bus_address = 16'h5555;
    bus_valid   = 1'b1;
    step();
    bus_valid = 1'b0;
    for (int c = 1; c < 10; c++) begin
      p_slot_data_in = p_slot_rd_n ? 8'hEE : 8'h42;
      step();
    end
    check("mid rd_low", int'(p_slot_rd_n), 0);
    reset = 1'b1;
    step();
    check("mid ctrl", int'({p_slot_sltsl_n, p_slot_mreq_n, p_slot_ioreq_n,
                            p_slot_rd_n, p_slot_wr_n}), 5'h1F);
    check("mid oe", int'(p_slot_data_oe), 0);
    check("mid slot_reset_n", int'(p_slot_reset_n), 0);
    check("mid ready", int'(bus_ready), 0);
    check("mid addr", int'(p_slot_address), 0);
    step();
    reset = 1'b0;
    step();
    check("mid rel slot_reset_n", int'(p_slot_reset_n), 1);
    en_cnt   = 0;
    idle_bad = 0;
    for (int c = 0; c < 30; c++) begin
      if (bus_rdata_en) en_cnt++;
      if (!p_slot_rd_n || !p_slot_sltsl_n || !bus_ready) idle_bad++;
      step();
    end
    check("mid no_rdata_en", en_cnt, 0);
    check("mid stays_idle", idle_bad, 0);

    // Back-to-back requests with valid held high.
    acc1 = -1;
    acc2 = -1;
    bus_memreq  = 1'b1;
    bus_address = 16'h0100;
    bus_valid   = 1'b1;
    for (int c = 0; c < 80; c++) begin
      p_slot_data_in = p_slot_rd_n ? 8'hEE : 8'h5A;
      if (bus_ready) begin
        if (acc1 < 0) acc1 = c;
        else if (acc2 < 0) acc2 = c;
      end
      step();
    end
    bus_valid  = 1'b0;
    bus_memreq = 1'b0;
    check("b2b first_accept", acc1, 0);
    check("b2b spacing", acc2 - acc1, 29);
    repeat (40) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
